// File: rtl/candidate_selector.sv
// candidate_selector
// Scans the hash table's per-window vote counts one window per cycle after a query,
// streams every window whose count reaches the threshold over a valid/ready port,
// and reports the lowest-indexed best-scoring window when the scan completes.
module candidate_selector #(
    parameter int MAX_WINDOWS_IN_REFERENCE = 512,
    parameter int SKETCH_SIZE              = 16
) (
    input  logic        clk,
    input  logic        reset_candidate_selector,
    input  logic        start,
    input  logic [31:0] num_windows,
    input  logic [31:0] threshold,
    input  logic [31:0] count_bus [0:MAX_WINDOWS_IN_REFERENCE-1],
    output logic        cand_valid,
    input  logic        cand_ready,
    output logic [31:0] cand_window_id,
    output logic [31:0] cand_count,
    output logic        busy,
    output logic        done,
    output logic [31:0] best_window_id,
    output logic [31:0] best_count,
    output logic [31:0] num_candidates
);

    localparam int IDX_W = (MAX_WINDOWS_IN_REFERENCE > 1) ? $clog2(MAX_WINDOWS_IN_REFERENCE) : 1;
    localparam int NW_W  = $clog2(MAX_WINDOWS_IN_REFERENCE + 1);

    // SKETCH_SIZE only bounds the vote values; counts are compared at full 32-bit width.
    if (SKETCH_SIZE < 1 || MAX_WINDOWS_IN_REFERENCE < 1) begin : g_param_check
        $error("candidate_selector: SKETCH_SIZE and MAX_WINDOWS_IN_REFERENCE must be positive");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [NW_W-1:0]  nw;
    logic [31:0]      thr_eff;
    logic [IDX_W-1:0] idx;
    logic [31:0]      cur_count;
    logic             slot_free;
    logic             last_idx;
    logic             emit;
    logic             improve;

    // Saturate the requested window count to the depth of count_bus.
    function automatic logic [NW_W-1:0] clamp_windows(input logic [31:0] n);
        if (n > 32'(MAX_WINDOWS_IN_REFERENCE))
            return NW_W'(MAX_WINDOWS_IN_REFERENCE);
        return n[NW_W-1:0];
    endfunction

    // A threshold of zero is raised to one so empty windows are never emitted.
    function automatic logic [31:0] floor_threshold(input logic [31:0] t);
        return (t == 32'd0) ? 32'd1 : t;
    endfunction

    assign cur_count = count_bus[idx];
    assign slot_free = !cand_valid || cand_ready;
    assign last_idx  = (NW_W'(idx) == (nw - NW_W'(1)));
    assign emit      = (cur_count >= thr_eff);
    assign improve   = (cur_count > best_count);
    assign busy      = (state == SCAN) || (state == DRAIN);
    assign done      = (state == DONE);

    // State register.
    always_ff @(posedge clk or posedge reset_candidate_selector) begin
        if (reset_candidate_selector)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic: a scan only advances when the output slot can take a new candidate.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start)
                    state_next = (clamp_windows(num_windows) == '0) ? DONE : SCAN;
            end
            SCAN: begin
                if (slot_free && last_idx)
                    state_next = DRAIN;
            end
            DRAIN: begin
                if (slot_free)
                    state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Scan datapath: latch the query, examine one window per free slot, track the best.
    always_ff @(posedge clk or posedge reset_candidate_selector) begin
        if (reset_candidate_selector) begin
            nw             <= '0;
            thr_eff        <= '0;
            idx            <= '0;
            cand_valid     <= 1'b0;
            cand_window_id <= '0;
            cand_count     <= '0;
            best_window_id <= '0;
            best_count     <= '0;
            num_candidates <= '0;
        end else begin
            // Release first so that a new candidate can be loaded in the same cycle.
            if (cand_valid && cand_ready)
                cand_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        nw             <= clamp_windows(num_windows);
                        thr_eff        <= floor_threshold(threshold);
                        idx            <= '0;
                        best_window_id <= '0;
                        best_count     <= '0;
                        num_candidates <= '0;
                    end
                end
                SCAN: begin
                    if (slot_free) begin
                        idx <= idx + 1'b1;
                        if (emit) begin
                            cand_valid     <= 1'b1;
                            cand_window_id <= 32'(idx);
                            cand_count     <= cur_count;
                            num_candidates <= num_candidates + 32'd1;
                        end
                        if (improve) begin
                            best_window_id <= 32'(idx);
                            best_count     <= cur_count;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
